// File: rtl/mem_gpiox.sv
// mem_gpiox: memory-mapped GPIO with alt-function muxing, atomic DO updates and edge interrupts.
// Define MEM_GPIOX_IRQ_EN to build RISE_EN/FALL_EN/PEND, the warm-up counter and irq.
module mem_gpiox #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [31:0]      mem_addr,
   output logic [31:0]      mem_rdata,
   input  logic [31:0]      mem_wdata,
   input  logic [3:0]       mem_wstrb,
   output logic [WIDTH-1:0] gpio_oe,
   output logic [WIDTH-1:0] gpio_do,
   input  logic [WIDTH-1:0] gpio_di,
   input  logic [WIDTH-1:0] alt_oe,
   input  logic [WIDTH-1:0] alt_do,
   output logic [WIDTH-1:0] alt_di,
   output logic             irq
);
   logic [WIDTH-1:0] alt_en, oe, dout, sync_di, m, wd, do_nxt, rd;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
   logic [31:0] bm;
   logic [3:0] off;
   logic acc, we;
   logic unused;
   assign unused  = &{1'b0, mem_addr[31:6], mem_addr[1:0]};
   assign acc     = mem_valid && !mem_ready;
   assign we      = acc && (mem_wstrb != 4'd0);
   assign off     = mem_addr[5:2];
   assign bm      = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
   assign m       = bm[WIDTH-1:0];
   assign wd      = mem_wdata[WIDTH-1:0] & m;
   assign sync_di = sync[SYNC_STAGES-1];
`ifdef MEM_GPIOX_IRQ_EN
   logic [WIDTH-1:0] rise_en, fall_en, pend, prev_di, edges;
   logic [2:0] warm;
   logic armed;
   // edges stay masked until the sync chain and prev_di hold post-reset samples
   assign armed = warm == 3'(SYNC_STAGES + 1);
   assign edges = armed ? (sync_di & ~prev_di & rise_en) | (~sync_di & prev_di & fall_en) : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         warm    <= '0;
         prev_di <= '0;
         rise_en <= '0;
         fall_en <= '0;
         pend    <= '0;
      end else begin
         warm    <= armed ? warm : warm + 3'd1;
         prev_di <= sync_di;
         if (we && off == 4'h7) rise_en <= (rise_en & ~m) | wd;
         if (we && off == 4'h8) fall_en <= (fall_en & ~m) | wd;
         pend <= (pend & ~((we && off == 4'h9) ? wd : '0)) | edges;
      end
   end
   assign irq = |pend;
`else
   logic [WIDTH-1:0] rise_en, fall_en, pend;
   assign rise_en = '0;
   assign fall_en = '0;
   assign pend    = '0;
   assign irq     = 1'b0;
`endif
   assign do_nxt = !we ? dout :
                   (off == 4'h2 || off == 4'h3) ? (dout & ~m) | wd :
                   off == 4'h4 ? dout | wd :
                   off == 4'h5 ? dout & ~wd :
                   off == 4'h6 ? dout ^ wd : dout;
   always_comb begin
      case (off)
         4'h0:                      rd = alt_en;
         4'h1:                      rd = oe;
         4'h2:                      rd = sync_di;
         4'h3, 4'h4, 4'h5, 4'h6:    rd = dout;
         4'h7:                      rd = rise_en;
         4'h8:                      rd = fall_en;
         4'h9:                      rd = pend;
         default:                   rd = '0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         sync      <= '0;
         alt_en    <= '0;
         oe        <= '0;
         dout      <= '0;
      end else begin
         mem_ready <= acc;
         mem_rdata <= acc ? 32'(rd) : 32'd0;
         sync      <= {sync[SYNC_STAGES-2:0], gpio_di};
         dout      <= do_nxt;
         if (we && off == 4'h0) alt_en <= (alt_en & ~m) | wd;
         if (we && off == 4'h1) oe <= (oe & ~m) | wd;
      end
   end
   assign gpio_oe = (alt_en & alt_oe) | (~alt_en & oe);
   assign gpio_do = (alt_en & alt_do) | (~alt_en & dout);
   assign alt_di  = alt_en & gpio_di;
endmodule

// File: tb/tb_mem_gpiox.sv
// tb_mem_gpiox: scoreboard bench for mem_gpiox; read expectations are queued and popped on mem_ready.
module tb_mem_gpiox;
   localparam int W = 32;
   localparam int S = 2;
   logic clk = 0, rst = 1;
   logic mem_valid = 0, mem_ready;
   logic [31:0] mem_addr = 0, mem_rdata, mem_wdata = 0;
   logic [3:0] mem_wstrb = 0;
   logic [W-1:0] gpio_oe, gpio_do, gpio_di = 0, alt_oe = 0, alt_do = 0, alt_di;
   logic irq;
   int total = 0, bad = 0;
   logic [31:0] q[$];
   logic [31:0] do_m = 0;

   mem_gpiox #(.WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .gpio_oe(gpio_oe), .gpio_do(gpio_do), .gpio_di(gpio_di),
      .alt_oe(alt_oe), .alt_do(alt_do), .alt_di(alt_di), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
      bit ok = 0;
      mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_valid = 1; r = '0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (mem_ready) begin r = mem_rdata; ok = 1; end
      end
      if (!ok) begin total++; bad++; $display("FAIL bus_timeout addr=%h: no mem_ready within 8 cycles", a); end
      @(posedge clk); #1;
      mem_valid = 0; mem_wstrb = 0;
   endtask

   task automatic test_reset;
      logic [31:0] r, e;
      @(negedge clk);
      total++;
      if ({mem_ready, irq, gpio_oe, gpio_do, alt_di, mem_rdata} !== '0) begin
         bad++; $display("FAIL reset_outputs: got rdy=%b irq=%b oe=%h do=%h adi=%h rd=%h want all 0",
                         mem_ready, irq, gpio_oe, gpio_do, alt_di, mem_rdata);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) q.push_back(32'h0);
      for (int i = 0; i < 16; i++) begin
         bus(32'(i * 4), 32'h0, 4'h0, r);
         e = q.pop_front(); total++;
         if (r !== e) begin bad++; $display("FAIL reset_read_%0h: got %h want %h", i * 4, r, e); end
      end
   endtask

   task automatic test_do;
      logic [31:0] r, e;
      bus(32'h0C, 32'hABCDFFFF, 4'b0011, r);
      total++;
      if (r !== do_m) begin bad++; $display("FAIL read_before_write: got %h want %h", r, do_m); end
      do_m = (do_m & ~32'h0000FFFF) | (32'hABCDFFFF & 32'h0000FFFF);
      bus(32'h10, 32'hF0000000, 4'hF, r); do_m |= 32'hF0000000;
      bus(32'h14, 32'h0000000F, 4'hF, r); do_m &= ~32'h0000000F;
      bus(32'h18, 32'h00000101, 4'hF, r); do_m ^= 32'h00000101;
      for (int i = 3; i <= 6; i++) q.push_back(do_m);
      for (int i = 3; i <= 6; i++) begin
         bus(32'(i * 4), 32'h0, 4'h0, r);
         e = q.pop_front(); total++;
         if (r !== e) begin bad++; $display("FAIL do_read_%0h: got %h want %h", i * 4, r, e); end
      end
      total++;
      if (gpio_do !== do_m) begin bad++; $display("FAIL gpio_do_atomic: got %h want %h", gpio_do, do_m); end
      bus(32'h10, 32'hFFFFFFFF, 4'b0100, r); do_m |= 32'h00FF0000;
      bus(32'h14, 32'hFFFFFFFF, 4'b1000, r); do_m &= ~32'hFF000000;
      q.push_back(do_m);
      bus(32'h0C, 32'h0, 4'h0, r);
      e = q.pop_front(); total++;
      if (r !== e) begin bad++; $display("FAIL do_strobed_set_clr: got %h want %h", r, e); end
      bus(32'h08, 32'h11223344, 4'hF, r); do_m = 32'h11223344;
      q.push_back(do_m);
      bus(32'h0C, 32'h0, 4'h0, r);
      e = q.pop_front(); total++;
      if (r !== e) begin bad++; $display("FAIL do_via_di_offset: got %h want %h", r, e); end
      total++;
      if (gpio_do !== do_m) begin bad++; $display("FAIL gpio_do_final: got %h want %h", gpio_do, do_m); end
   endtask

   task automatic test_alt;
      logic [31:0] r, e;
      bus(32'h04, 32'h000000A5, 4'hF, r);
      q.push_back(32'hA5);
      bus(32'h04, 32'h0, 4'h0, r);
      e = q.pop_front(); total++;
      if (r !== e || gpio_oe !== 32'hA5) begin bad++; $display("FAIL oe_rw: got rd=%h pad=%h want %h", r, gpio_oe, e); end
      bus(32'h04, 32'h0, 4'hF, r);
      bus(32'h00, 32'h1, 4'hF, r);
      alt_oe = 1; alt_do = 1; gpio_di = '1;
      #1 total++;
      if (gpio_oe !== 32'h1 || gpio_do !== (do_m | 32'h1) || alt_di !== 32'h1) begin
         bad++; $display("FAIL alt_on: got oe=%h do=%h adi=%h want 1 %h 1", gpio_oe, gpio_do, alt_di, do_m | 32'h1);
      end
      bus(32'h00, 32'h0, 4'hF, r);
      #1 total++;
      if (gpio_oe !== 32'h0 || gpio_do !== do_m || alt_di !== 32'h0) begin
         bad++; $display("FAIL alt_off: got oe=%h do=%h adi=%h want 0 %h 0", gpio_oe, gpio_do, alt_di, do_m);
      end
      alt_oe = 0; alt_do = 0; gpio_di = 32'h12345678;
      repeat (S + 2) @(posedge clk);
      #1 q.push_back(32'h12345678);
      bus(32'h08, 32'h0, 4'h0, r);
      e = q.pop_front(); total++;
      if (r !== e) begin bad++; $display("FAIL di_read: got %h want %h", r, e); end
      gpio_di = 0;
      repeat (S + 3) @(posedge clk);
      #1;
   endtask

   task automatic test_unmapped;
      logic [31:0] r, e;
`ifdef MEM_GPIOX_IRQ_EN
      int first = 10;
`else
      int first = 7;
`endif
      for (int i = first; i < 16; i++) bus(32'(i * 4), 32'hFFFFFFFF, 4'hF, r);
      for (int i = first; i < 16; i++) q.push_back(32'h0);
      q.push_back(do_m);
      for (int i = first; i < 17; i++) begin
         bus(i == 16 ? 32'h0C : 32'(i * 4), 32'h0, 4'h0, r);
         e = q.pop_front(); total++;
         if (r !== e) begin bad++; $display("FAIL unmapped_%0h: got %h want %h", i * 4, r, e); end
      end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL unmapped_irq: got %b want 0", irq); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r0, r1, e;
      bit ok = 0;
      q.push_back(do_m); q.push_back(32'h0);
      mem_addr = 32'h0C; mem_wstrb = 0; mem_valid = 1; r0 = 0; r1 = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (mem_ready) begin r0 = mem_rdata; ok = 1; end
      end
      if (!ok) begin total++; bad++; $display("FAIL b2b_timeout: no mem_ready"); end
      @(posedge clk); #1 mem_addr = 32'h08;
      @(negedge clk); total++;
      if (mem_ready !== 1'b0) begin bad++; $display("FAIL b2b_gap: got ready=%b want 0", mem_ready); end
      @(negedge clk); total++;
      if (mem_ready !== 1'b1) begin bad++; $display("FAIL b2b_second: got ready=%b want 1", mem_ready); end
      r1 = mem_rdata;
      @(posedge clk); #1 mem_valid = 0;
      e = q.pop_front(); total++;
      if (r0 !== e) begin bad++; $display("FAIL b2b_data0: got %h want %h", r0, e); end
      e = q.pop_front(); total++;
      if (r1 !== e) begin bad++; $display("FAIL b2b_data1: got %h want %h", r1, e); end
   endtask

`ifdef MEM_GPIOX_IRQ_EN
   task automatic test_rise;
      logic [31:0] r, e;
      bus(32'h1C, 32'h4, 4'hF, r);
      gpio_di[2] = 1;
      repeat (S) @(posedge clk);
      @(negedge clk); total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq); end
      @(posedge clk);
      @(negedge clk); total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_latency: got %b want 1", irq); end
      @(posedge clk); #1;
      q.push_back(32'h4);
      bus(32'h24, 32'h0, 4'h0, r);
      e = q.pop_front(); total++;
      if (r !== e) begin bad++; $display("FAIL pend_rise: got %h want %h", r, e); end
      bus(32'h24, 32'h4, 4'hF, r);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c: got %b want 0", irq); end
      q.push_back(32'h0);
      bus(32'h24, 32'h0, 4'h0, r);
      e = q.pop_front(); total++;
      if (r !== e) begin bad++; $display("FAIL pend_cleared: got %h want %h", r, e); end
   endtask

   task automatic test_same_cycle;
      logic [31:0] r, e;
      bus(32'h20, 32'h8, 4'hF, r);
      gpio_di[3] = 1;
      repeat (S + 3) @(posedge clk);
      #1 gpio_di[3] = 0;
      repeat (S) @(posedge clk);
      #1 bus(32'h24, 32'h8, 4'hF, r);
      q.push_back(32'h8);
      bus(32'h24, 32'h0, 4'h0, r);
      e = q.pop_front(); total++;
      if (r !== e || irq !== 1'b1) begin bad++; $display("FAIL set_wins: got pend=%h irq=%b want %h 1", r, irq, e); end
   endtask

   task automatic test_warmup;
      logic [31:0] r, e;
      bit ok = 0;
      rst = 1; gpio_di = '1;
      mem_addr = 32'h1C; mem_wdata = '1; mem_wstrb = 4'hF; mem_valid = 1;
      repeat (3) @(posedge clk);
      @(negedge clk); total++;
      if (mem_ready !== 1'b0) begin bad++; $display("FAIL ready_in_reset: got %b want 0", mem_ready); end
      @(posedge clk); #1 rst = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (mem_ready) ok = 1;
      end
      if (!ok) begin total++; bad++; $display("FAIL warmup_timeout: no mem_ready"); end
      @(posedge clk); #1 mem_valid = 0; mem_wstrb = 0;
      repeat (10) @(posedge clk);
      #1 q.push_back(32'h0);
      bus(32'h24, 32'h0, 4'h0, r);
      e = q.pop_front(); total++;
      if (r !== e || irq !== 1'b0) begin bad++; $display("FAIL warmup_pend: got pend=%h irq=%b want %h 0", r, irq, e); end
      gpio_di[5] = 0;
      repeat (S + 3) @(posedge clk);
      #1 gpio_di[5] = 1;
      repeat (S + 3) @(posedge clk);
      #1 q.push_back(32'h20);
      bus(32'h24, 32'h0, 4'h0, r);
      e = q.pop_front(); total++;
      if (r !== e) begin bad++; $display("FAIL post_warmup_edge: got %h want %h", r, e); end
   endtask
`endif

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      test_reset;
      test_do;
      test_alt;
      test_unmapped;
      test_back_to_back;
`ifdef MEM_GPIOX_IRQ_EN
      test_rise;
      test_same_cycle;
      test_warmup;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
